// File: rtl/pc_gen_unit.sv
// pc_gen_unit: fetch-stage program-counter generator with handshake, stall, buffered redirect, trap priority and misalign vectoring
// Ports:
//   clk, rst (sync, active-low)
//   stall_i        hazard hold; freezes PC, drops fetch_valid_o
//   fetch_ready_i  instruction memory accepts current request
//   branch_en_i / branch_pc_i  branch redirect request and target
//   trap_en_i / trap_pc_i      trap redirect request and handler address
//   pc_o, pc_plus_o            current fetch address and its sequential successor
//   fetch_valid_o              fetch request valid
//   misalign_o / badaddr_o     misaligned-branch pulse and captured target
module pc_gen_unit #(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int INST_BYTES = 4,
    parameter logic [31:0] MISALIGN_VEC = 32'h00000100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              fetch_ready_i,
    input  logic              branch_en_i,
    input  logic [ADDR_W-1:0] branch_pc_i,
    input  logic              trap_en_i,
    input  logic [ADDR_W-1:0] trap_pc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus_o,
    output logic              fetch_valid_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] badaddr_o
);
    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;
    localparam logic [ADDR_W-1:0] LO = ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] MIS = ADDR_W'(MISALIGN_VEC);
    state_t state, state_n;
    logic [ADDR_W-1:0] pc_n, pend, pend_n, bad_n, tgt;
    logic mis_n, apply, tgt_bad;
    assign pc_plus_o = pc_o + ADDR_W'(INST_BYTES);
    assign fetch_valid_o = (state == RUN) && !stall_i;
    // a live branch always takes precedence over the buffered one
    assign tgt = branch_en_i ? branch_pc_i : pend;
    assign tgt_bad = |(tgt & LO);
    always_comb begin
        state_n = state;
        pc_n = pc_o;
        pend_n = pend;
        bad_n = badaddr_o;
        mis_n = 1'b0;
        apply = 1'b0;
        if (trap_en_i) begin
            pc_n = trap_pc_i & ~LO;
            pend_n = '0;
            state_n = RUN;
        end else if (branch_en_i && stall_i) begin
            pend_n = branch_pc_i;
            state_n = PEND;
        end else if (branch_en_i || (state == PEND && !stall_i)) begin
            apply = 1'b1;
            state_n = RUN;
        end else if (state == BOOT) begin
            state_n = RUN;
        end else if (fetch_valid_o && fetch_ready_i) begin
            pc_n = pc_plus_o;
        end
        if (apply) begin
            pc_n = tgt_bad ? MIS : tgt;
            bad_n = tgt_bad ? tgt : badaddr_o;
            mis_n = tgt_bad;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= BOOT;
            pc_o <= RESET_VEC;
            pend <= '0;
            badaddr_o <= '0;
            misalign_o <= 1'b0;
        end else begin
            state <= state_n;
            pc_o <= pc_n;
            pend <= pend_n;
            badaddr_o <= bad_n;
            misalign_o <= mis_n;
        end
    end
endmodule

// File: tb/tb_pc_gen_unit.sv
// tb_pc_gen_unit: table-driven scoreboard bench for pc_gen_unit (32-bit/4-byte and 16-bit/2-byte builds)
module tb_pc_gen_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, stall, ready, be, te;
    logic [31:0] bpc, tpc, pc, pp, bad;
    logic v, m;
    pc_gen_unit #(.ADDR_W(32), .RESET_VEC(32'h80000000), .INST_BYTES(4), .MISALIGN_VEC(32'h00000100)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .fetch_ready_i(ready),
        .branch_en_i(be), .branch_pc_i(bpc), .trap_en_i(te), .trap_pc_i(tpc),
        .pc_o(pc), .pc_plus_o(pp), .fetch_valid_o(v), .misalign_o(m), .badaddr_o(bad)
    );

    logic rst2, stall2, ready2, be2, te2;
    logic [15:0] bpc2, tpc2, pc2, pp2, bad2;
    logic v2, m2;
    pc_gen_unit #(.ADDR_W(16), .RESET_VEC(16'h0040), .INST_BYTES(2), .MISALIGN_VEC(32'h00010100)) dut2 (
        .clk(clk), .rst(rst2), .stall_i(stall2), .fetch_ready_i(ready2),
        .branch_en_i(be2), .branch_pc_i(bpc2), .trap_en_i(te2), .trap_pc_i(tpc2),
        .pc_o(pc2), .pc_plus_o(pp2), .fetch_valid_o(v2), .misalign_o(m2), .badaddr_o(bad2)
    );

    typedef struct {
        logic r, s, rd, be;
        logic [31:0] bpc;
        logic te;
        logic [31:0] tpc;
        logic [31:0] pc;
        logic v, m;
        logic [31:0] bad;
    } vec_t;
    typedef struct {
        logic [31:0] pc, pp, bad;
        logic v, m;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    function automatic vec_t mk(logic r, logic s, logic rd, logic b, logic [31:0] bp, logic t, logic [31:0] tp,
                                logic [31:0] epc, logic ev, logic em, logic [31:0] ebad);
        vec_t x;
        x.r = r; x.s = s; x.rd = rd; x.be = b; x.bpc = bp; x.te = t; x.tpc = tp;
        x.pc = epc; x.v = ev; x.m = em; x.bad = ebad;
        return x;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step2(logic r, logic s, logic rd, logic b, logic [15:0] bp, logic t, logic [15:0] tp,
                         logic [15:0] epc, logic [15:0] epp, logic ev, logic em, logic [15:0] ebad, string tag);
        @(negedge clk);
        rst2 = r; stall2 = s; ready2 = rd; be2 = b; bpc2 = bp; te2 = t; tpc2 = tp;
        @(posedge clk);
        #1;
        check({tag, ".pc"}, 32'(pc2), 32'(epc));
        check({tag, ".pc_plus"}, 32'(pp2), 32'(epp));
        check({tag, ".valid"}, 32'(v2), 32'(ev));
        check({tag, ".misalign"}, 32'(m2), 32'(em));
        check({tag, ".badaddr"}, 32'(bad2), 32'(ebad));
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; ready = 1'b0; be = 1'b0; te = 1'b0; bpc = '0; tpc = '0;
        rst2 = 1'b0; stall2 = 1'b0; ready2 = 1'b0; be2 = 1'b0; te2 = 1'b0; bpc2 = '0; tpc2 = '0;
        //                r  s  rd be bpc           te tpc           pc            v  m  bad
        vecs.push_back(mk(0, 0, 1, 0, 0,            0, 0,            32'h80000000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,            0, 0,            32'h80000000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,            0, 0,            32'h80000000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0,            0, 0,            32'h80000000, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0,            0, 0,            32'h80000004, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0,            0, 0,            32'h80000008, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0,            1, 32'h10,       32'h10,       1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,            0, 0,            32'h10,       1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,            0, 0,            32'h10,       1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,            0, 0,            32'h10,       1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0,            0, 0,            32'h14,       1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 32'h200,      0, 0,            32'h14,       0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0,            0, 0,            32'h14,       0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 32'h300,      0, 0,            32'h14,       0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0,            0, 0,            32'h14,       0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0,            0, 0,            32'h14,       0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0,            0, 0,            32'h300,      1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0,            0, 0,            32'h304,      1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 32'h400,      1, 32'h1003,     32'h1000,     0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0,            0, 0,            32'h1000,     0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,            0, 0,            32'h1000,     1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0,            0, 0,            32'h1004,     1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 32'h102,      0, 0,            32'h100,      1, 1, 32'h102));
        vecs.push_back(mk(1, 0, 0, 0, 0,            0, 0,            32'h100,      1, 0, 32'h102));
        vecs.push_back(mk(1, 0, 1, 0, 0,            0, 0,            32'h104,      1, 0, 32'h102));
        vecs.push_back(mk(1, 0, 1, 0, 0,            1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0, 32'h102));
        vecs.push_back(mk(1, 0, 1, 0, 0,            0, 0,            32'h0,        1, 0, 32'h102));
        vecs.push_back(mk(1, 1, 1, 1, 32'h206,      0, 0,            32'h0,        0, 0, 32'h102));
        vecs.push_back(mk(1, 0, 1, 0, 0,            0, 0,            32'h100,      1, 1, 32'h206));
        vecs.push_back(mk(1, 1, 1, 1, 32'h30A,      0, 0,            32'h100,      0, 0, 32'h206));
        vecs.push_back(mk(1, 0, 1, 0, 0,            1, 32'h2000,     32'h2000,     1, 0, 32'h206));
        vecs.push_back(mk(1, 0, 0, 0, 0,            0, 0,            32'h2000,     1, 0, 32'h206));
        vecs.push_back(mk(1, 1, 1, 1, 32'h500,      0, 0,            32'h2000,     0, 0, 32'h206));
        vecs.push_back(mk(0, 0, 1, 0, 0,            0, 0,            32'h80000000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,            0, 0,            32'h80000000, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0,            0, 0,            32'h80000004, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,            0, 0,            32'h80000000, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 32'h600,      0, 0,            32'h80000000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0,            0, 0,            32'h600,      1, 0, 0));

        foreach (vecs[i]) begin
            exp_t e;
            exp_t g;
            @(negedge clk);
            rst = vecs[i].r; stall = vecs[i].s; ready = vecs[i].rd;
            be = vecs[i].be; bpc = vecs[i].bpc; te = vecs[i].te; tpc = vecs[i].tpc;
            e.pc = vecs[i].pc; e.pp = vecs[i].pc + 32'd4; e.v = vecs[i].v; e.m = vecs[i].m; e.bad = vecs[i].bad;
            sb.push_back(e);
            @(posedge clk);
            #1;
            g = sb.pop_front();
            check($sformatf("v%0d.pc", i), pc, g.pc);
            check($sformatf("v%0d.pc_plus", i), pp, g.pp);
            check($sformatf("v%0d.valid", i), 32'(v), 32'(g.v));
            check($sformatf("v%0d.misalign", i), 32'(m), 32'(g.m));
            check($sformatf("v%0d.badaddr", i), bad, g.bad);
        end

        // 16-bit build, 2-byte instructions: wrap at FFFE and truncated misalign vector
        step2(0, 0, 1, 0, 0,        0, 0,        16'h0040, 16'h0042, 0, 0, 16'h0000, "w_reset");
        step2(1, 0, 1, 0, 0,        0, 0,        16'h0040, 16'h0042, 1, 0, 16'h0000, "w_boot");
        step2(1, 0, 1, 0, 0,        0, 0,        16'h0042, 16'h0044, 1, 0, 16'h0000, "w_inc");
        step2(1, 0, 1, 0, 0,        1, 16'hFFFF, 16'hFFFE, 16'h0000, 1, 0, 16'h0000, "w_trap");
        step2(1, 0, 1, 0, 0,        0, 0,        16'h0000, 16'h0002, 1, 0, 16'h0000, "w_wrap");
        step2(1, 0, 1, 1, 16'h0103, 0, 0,        16'h0100, 16'h0102, 1, 1, 16'h0103, "w_mis");
        step2(1, 0, 0, 1, 16'h0106, 0, 0,        16'h0106, 16'h0108, 1, 0, 16'h0103, "w_aligned");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
